// File: rtl/iram_ctrl_if.sv
// Core/RAM-side signal bundle for iram_ctrl: request, completion and RAM control.
// Handshake: req is held by the core until the cycle it is sampled in IDLE with busy=0 and
// sp_we=0; that edge accepts it, busy rises next cycle and done pulses once when finished.
interface iram_ctrl_if;
    logic       req;
    logic [2:0] op;
    logic [7:0] addr;
    logic [7:0] bit_addr;
    logic [1:0] bank;
    logic       ri_sel;
    logic [7:0] wdata;
    logic       wbit;
    logic       sp_we;
    logic [7:0] sp_wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rdata;
    logic       rbit;
    logic [7:0] sp;
    logic       ram_cs_n;
    logic       ram_rw;
    logic       ram_bb;
    logic [7:0] ram_addr;
    logic [7:0] ram_pos;
    logic [7:0] ram_din;
    logic       ram_bin;
    logic [7:0] ram_dout;
    logic       ram_bout;

    modport master (
        output req, op, addr, bit_addr, bank, ri_sel, wdata, wbit, sp_we, sp_wdata,
               ram_dout, ram_bout,
        input  busy, done, err, rdata, rbit, sp,
               ram_cs_n, ram_rw, ram_bb, ram_addr, ram_pos, ram_din, ram_bin
    );

    modport slave (
        input  req, op, addr, bit_addr, bank, ri_sel, wdata, wbit, sp_we, sp_wdata,
               ram_dout, ram_bout,
        output busy, done, err, rdata, rbit, sp,
               ram_cs_n, ram_rw, ram_bb, ram_addr, ram_pos, ram_din, ram_bin
    );
endinterface

// File: rtl/iram_ctrl.sv
// MCU51 internal-RAM access sequencer (direct, bit, indirect, PUSH/POP).
// Define IRAM_CTRL_SP_EN to build the stack pointer, PUSH/POP and sp_we support.
module iram_ctrl #(
    parameter int RD_LAT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    iram_ctrl_if.slave bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, PTR = 2'd1, ACC = 2'd2, DONE = 2'd3} state_t;

    localparam logic [2:0] OP_RDBYTE = 3'b000;
    localparam logic [2:0] OP_WRBYTE = 3'b001;
    localparam logic [2:0] OP_RDBIT  = 3'b010;
    localparam logic [2:0] OP_WRBIT  = 3'b011;
    localparam logic [2:0] OP_RDIND  = 3'b100;
    localparam logic [2:0] OP_WRIND  = 3'b101;
    localparam logic [2:0] OP_PUSH   = 3'b110;
    localparam logic [2:0] OP_POP    = 3'b111;
    localparam logic [1:0] LAT       = 2'(RD_LAT);

    state_t     state, state_nx;
    logic [2:0] op_q;
    logic [7:0] addr_q;
    logic [6:0] bit_addr_q;
    logic [1:0] bank_q;
    logic       ri_q;
    logic [7:0] wdata_q;
    logic       wbit_q;
    logic [7:0] ptr_q;
    logic [1:0] cnt;
    logic       err_q;
    logic [7:0] rdata_q;
    logic       rbit_q;
    logic [7:0] sp_q;

    logic sp_load, in_rej, accept, is_bit, is_write, is_ind, lat_end, acc_last;

    assign is_bit   = (op_q == OP_RDBIT) || (op_q == OP_WRBIT);
    assign is_write = (op_q == OP_WRBYTE) || (op_q == OP_WRBIT) ||
                      (op_q == OP_WRIND)  || (op_q == OP_PUSH);
    assign is_ind   = (op_q == OP_RDIND) || (op_q == OP_WRIND);
    assign lat_end  = (cnt == LAT);
    assign acc_last = is_write || lat_end;
    assign accept   = (state == IDLE) && bus.req && !sp_load;

`ifdef IRAM_CTRL_SP_EN
    assign sp_load = bus.sp_we;
    assign in_rej  = ((bus.op == OP_RDBIT) || (bus.op == OP_WRBIT)) && bus.bit_addr[7];

    // PUSH pre-increments in its single write cycle; POP post-decrements after the read lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q <= 8'h07;
        end else if (state == IDLE && sp_load) begin
            sp_q <= bus.sp_wdata;
        end else if (state == ACC && op_q == OP_PUSH) begin
            sp_q <= sp_q + 8'd1;
        end else if (state == ACC && op_q == OP_POP && acc_last) begin
            sp_q <= sp_q - 8'd1;
        end
    end
`else
    logic sp_unused;
    assign sp_unused = ^{bus.sp_we, bus.sp_wdata};
    assign sp_load   = 1'b0;
    assign in_rej    = (((bus.op == OP_RDBIT) || (bus.op == OP_WRBIT)) && bus.bit_addr[7]) ||
                       (bus.op[2:1] == 2'b11);
    assign sp_q      = 8'h07;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_rej)
                        state_nx = DONE;
                    else if ((bus.op == OP_RDIND) || (bus.op == OP_WRIND))
                        state_nx = PTR;
                    else
                        state_nx = ACC;
                end
            end
            PTR:  if (lat_end) state_nx = ACC;
            ACC:  if (acc_last) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= 3'd0;
            addr_q     <= 8'd0;
            bit_addr_q <= 7'd0;
            bank_q     <= 2'd0;
            ri_q       <= 1'b0;
            wdata_q    <= 8'd0;
            wbit_q     <= 1'b0;
            ptr_q      <= 8'd0;
            cnt        <= 2'd0;
            err_q      <= 1'b0;
            rdata_q    <= 8'd0;
            rbit_q     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    cnt <= 2'd0;
                    if (accept) begin
                        op_q       <= bus.op;
                        addr_q     <= bus.addr;
                        bit_addr_q <= bus.bit_addr[6:0];
                        bank_q     <= bus.bank;
                        ri_q       <= bus.ri_sel;
                        wdata_q    <= bus.wdata;
                        wbit_q     <= bus.wbit;
                        err_q      <= in_rej;
                    end
                end
                PTR: begin
                    if (lat_end) begin
                        ptr_q <= bus.ram_dout;
                        cnt   <= 2'd0;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                ACC: begin
                    cnt <= cnt + 2'd1;
                    if (acc_last && !is_write) begin
                        if (is_bit) rbit_q  <= bus.ram_bout;
                        else        rdata_q <= bus.ram_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.ram_cs_n = 1'b1;
        bus.ram_rw   = 1'b1;
        bus.ram_bb   = 1'b0;
        bus.ram_addr = 8'h00;
        bus.ram_pos  = 8'h00;
        bus.ram_din  = 8'h00;
        bus.ram_bin  = 1'b0;
        if (state == PTR) begin
            bus.ram_cs_n = 1'b0;
            bus.ram_bb   = 1'b1;
            bus.ram_addr = {3'b000, bank_q, 2'b00, ri_q};
            bus.ram_pos  = 8'hFF;
        end else if (state == ACC) begin
            bus.ram_cs_n = 1'b0;
            bus.ram_rw   = !is_write;
            if (is_bit) begin
                // Bit space 00..7F maps onto bytes 20..2F, eight bits per byte.
                bus.ram_addr = 8'h20 + {4'h0, bit_addr_q[6:3]};
                bus.ram_pos  = 8'h01 << bit_addr_q[2:0];
                bus.ram_bin  = (op_q == OP_WRBIT) ? wbit_q : 1'b0;
            end else begin
                bus.ram_bb  = 1'b1;
                bus.ram_pos = 8'hFF;
                bus.ram_din = is_write ? wdata_q : 8'h00;
                case (op_q)
                    OP_RDIND, OP_WRIND: bus.ram_addr = ptr_q;
                    OP_PUSH:            bus.ram_addr = sp_q + 8'd1;
                    OP_POP:             bus.ram_addr = sp_q;
                    default:            bus.ram_addr = addr_q;
                endcase
            end
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
    assign bus.err   = (state == DONE) && err_q;
    assign bus.rdata = rdata_q;
    assign bus.rbit  = rbit_q;
    assign bus.sp    = sp_q;
    assign dbg_state = state;

    logic unused_ind;
    assign unused_ind = is_ind;
endmodule
